mips_cpu_sequencer: RTL
=======================

# mips_cpu_sequencer

Multicycle state sequencer for the MIPS CPU: owns the 3-bit `state` register driving the instruction controller (1 fetch, 2 decode, 3 exec1, 4 exec2). Consumes the controller's `threecycle`, `memread` and `memwrite` outputs, the memory `waitrequest` and the architectural PC. It produces stall, write-enable gating, halt/active status, and instruction and cycle counters. It sits directly upstream of the controller and closes the loop between it and the memory interface.

## Interface
- `CNT_W`, default 32, width of `instr_count` and `cycle_count`.
- `clk`, input, 1, sole clock; all state updates on the rising edge.
- `reset`, input, 1, synchronous, active-high.
- `waitrequest`, input, 1, memory not ready; the current memory access must be held.
- `threecycle`, input, 1, from the controller; the instruction completes in exec1.
- `memread`, input, 1, from the controller; valid in states 3 and 4.
- `memwrite`, input, 1, from the controller; valid in states 3 and 4.
- `pc`, input, 32, current PC register value.
- `state`, output, 3, sequencer state, fed to the controller.
- `active`, output, 1, CPU running.
- `stall`, output, 1, current state is held due to `waitrequest`.
- `mem_en`, output, 1, qualifies controller `memread` and `memwrite` toward memory.
- `wr_en`, output, 1, qualifies `irwrite`, `pcwrite`, `pcwritecond` and `regwrite`.
- `instr_count`, output, `CNT_W`, retired instructions.
- `cycle_count`, output, `CNT_W`, cycles spent active.

## Operation
- State encoding:
  - IDLE = 0
  - FETCH = 1
  - DECODE = 2
  - EXEC1 = 3
  - EXEC2 = 4
  - HALT = 5
  - Codes 6 and 7 are illegal and go to HALT on the next edge.
- `mem_access` = (`state`==1) | ((`state`==3 | `state`==4) & (`memread` | `memwrite`)).
- `stall` = `mem_access` & `waitrequest`.
- `halting` = (`state`==1) & (`pc`==0).
- `mem_en` = (`state` in 1..4) & !`halting`.
- `wr_en` = `mem_en` & !`stall`.
- `active` = (`state` in 1..4).
- `stall`, `mem_en`, `wr_en`, `active` and `halting` are combinational from `state` and the inputs.
- Transitions on each rising edge, with `reset` low:
  - IDLE -> FETCH, unconditionally.
  - FETCH:
    - `halting` -> HALT; no fetch is issued.
    - Otherwise `stall` -> FETCH.
    - Otherwise -> DECODE.
  - DECODE -> EXEC1, unconditionally; no memory access, never stalls.
  - EXEC1:
    - `stall` -> EXEC1.
    - Otherwise `threecycle` -> FETCH and retire.
    - Otherwise -> EXEC2.
  - EXEC2:
    - `stall` -> EXEC2.
    - Otherwise -> FETCH and retire.
  - HALT -> HALT until `reset`.
- Retire: `instr_count` += 1 on the edge leaving EXEC1 or EXEC2 for FETCH.
- `cycle_count` += 1 on every edge where `active`=1, stall cycles included.
- Both counters wrap modulo 2^`CNT_W` with no saturation and no flag.
- `halting` takes priority over `waitrequest` in FETCH: `pc`==0 goes to HALT even if `waitrequest`=1.
- `threecycle` is ignored in EXEC2. `memread`/`memwrite` are ignored outside EXEC1/EXEC2.

## Timing
- Reset values, on the edge where `reset`=1:
  - `state`=0, `instr_count`=0, `cycle_count`=0.
  - Combinational outputs while in IDLE: `active`=0, `stall`=0, `mem_en`=0, `wr_en`=0.
- `reset` asserted in any state, including mid-stall or HALT, returns the sequencer to IDLE on that edge and clears the counters. There is no partial retire.
- First FETCH occurs one cycle after `reset` is deasserted.
- Unstalled latency:
  - three-cycle instruction: 3 cycles, FETCH -> DECODE -> EXEC1.
  - four-cycle instruction: 4 cycles, adds EXEC2.
- Each cycle with `stall`=1 adds exactly one cycle. `state` is unchanged during a stall.
- During a stall, `mem_en` stays 1 so the access is held, and `wr_en`=0 so IR, PC and the register file are not written.
- `waitrequest` is sampled every cycle. An access completes in the first cycle where it is 0, and that cycle has `wr_en`=1.
- In HALT: `active`=0, `mem_en`=0, `wr_en`=0, and both counters are frozen.

## Test plan
- Reset then three-cycle ALU instruction:
  - Stimulus: `reset` high 2 cycles then low; `pc`=0x4; `threecycle`=1; `waitrequest`=0.
  - Response: `state` sequence 0,1,2,3,1; `instr_count`=1 after 4 edges; `cycle_count`=3.
- Four-cycle load:
  - Stimulus: `threecycle`=0; `memread`=1 in EXEC1.
  - Response: `state` 1,2,3,4,1; `instr_count` increments only on the 4->1 edge.
- Fetch stall:
  - Stimulus: `waitrequest`=1 for 3 cycles in FETCH.
  - Response: `state` stays 1 for 4 cycles; `stall`=1, `mem_en`=1, `wr_en`=0 for 3 cycles; `cycle_count` +4 before DECODE.
- Exec1 store stall:
  - Stimulus: `memwrite`=1, `threecycle`=1, `waitrequest`=1 for 2 cycles.
  - Response: EXEC1 held for 3 cycles; retires once.
- Exec1 no-access case:
  - Stimulus: `waitrequest`=1 with `memread`=`memwrite`=0.
  - Response: `stall`=0; no hold.
- Halt:
  - Stimulus: `pc`=0 in FETCH, with `waitrequest`=1.
  - Response: `mem_en`=0 that cycle; HALT (5) next; `active`=0; counters frozen for 10 cycles.
- Counter wrap and reset:
  - Stimulus: `CNT_W`=4; run 17 three-cycle instructions.
  - Response: `instr_count`=1.
  - Stimulus: `reset` asserted in EXEC2.
  - Response: `state`=0 and counters 0 next edge.

Source files
------------

// File: rtl/mips_cpu_sequencer.sv
// Multicycle state sequencer for the MIPS CPU: drives the controller state,
// gates memory and architectural writes on waitrequest, and counts work done.
module mips_cpu_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             waitrequest,
    input  logic             threecycle,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [31:0]      pc,
    output logic [2:0]       state,
    output logic             active,
    output logic             stall,
    output logic             mem_en,
    output logic             wr_en,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC1  = 3'd3,
        EXEC2  = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t cur;
    logic   in_fetch;
    logic   in_exec;
    logic   mem_access;
    logic   halting;

    assign state      = cur;
    assign in_fetch   = (cur == FETCH);
    assign in_exec    = (cur == EXEC1) || (cur == EXEC2);
    assign mem_access = in_fetch || (in_exec && (memread || memwrite));
    assign stall      = mem_access && waitrequest;
    assign halting    = in_fetch && (pc == 32'd0);
    assign active     = (cur == FETCH) || (cur == DECODE) || in_exec;
    assign mem_en     = active && !halting;
    assign wr_en      = mem_en && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= IDLE;
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            if (active) begin
                cycle_count <= cycle_count + 1'b1;
            end
            case (cur)
                IDLE:   cur <= FETCH;
                FETCH: begin
                    // A zero PC halts before any fetch, even while memory is busy.
                    if (halting) begin
                        cur <= HALT;
                    end else if (!stall) begin
                        cur <= DECODE;
                    end
                end
                DECODE: cur <= EXEC1;
                EXEC1: begin
                    if (!stall) begin
                        if (threecycle) begin
                            cur         <= FETCH;
                            instr_count <= instr_count + 1'b1;
                        end else begin
                            cur <= EXEC2;
                        end
                    end
                end
                EXEC2: begin
                    if (!stall) begin
                        cur         <= FETCH;
                        instr_count <= instr_count + 1'b1;
                    end
                end
                HALT:    cur <= HALT;
                default: cur <= HALT;
            endcase
        end
    end

endmodule
